// File: rtl/sram_req_pkg.sv
// sram_req_pkg: shared widths and request/response records for sram_req_master
package sram_req_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int BE_W = DATA_W / 8;
  typedef struct packed {
    logic              is_wr;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;
  typedef struct packed {
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;
endpackage

// File: rtl/sram_req_if.sv
// sram_req_if: request/response stream between a compute engine (master) and sram_req_master (slave)
interface sram_req_if #(
  parameter int ADDR_W = sram_req_pkg::ADDR_W,
  parameter int DATA_W = sram_req_pkg::DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W/8-1:0] req_be;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_is_wr;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  modport master (
    output req_valid, req_be, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_is_wr, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_be, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_is_wr, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: synchronous response FIFO with occupancy count; push/pop may coincide, pop on empty is ignored
module sram_rsp_fifo
  import sram_req_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  rsp_t          din,
  output rsp_t          dout,
  output logic [CW-1:0] count
);
  rsp_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign do_pop = pop & (count != '0);
  assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
  assign dout = mem[rd];
  // storage needs no reset: entries are only visible through count
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      rd <= rd + AW'(do_pop);
      wr <= wr + AW'(do_push);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/sram_req_master.sv
// sram_req_master: valid/ready requests to SRAM port cycles with credit-protected in-order responses; SRAM_REQ_BOUNDS_CHK_EN enables the address bounds check
module sram_req_master #(
  parameter int ADDR_W = sram_req_pkg::ADDR_W,
  parameter int DATA_W = sram_req_pkg::DATA_W,
  parameter int DEPTH = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  sram_req_if.slave           bus,
  output logic [DATA_W/8-1:0] sram_wea,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);
  import sram_req_pkg::rsp_t, sram_req_pkg::req_t;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] FD = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  req_t req;
  rsp_t rsp_in, rsp_head;
  logic [CW-1:0] count;
  logic [CW:0] used;
  logic rdy_q, ready, accept, oob, err, rsp_v;
  logic s0_v, s0_wr, s0_err, s1_v, s1_wr, s1_err;
  assign req = '{be: bus.req_be, addr: bus.req_addr, wdata: bus.req_wdata};
  assign oob = {1'b0, req.addr} >= LIMIT;
`ifdef SRAM_REQ_BOUNDS_CHK_EN
  assign err = oob;
`else
  logic unused_oob;
  assign unused_oob = oob;
  assign err = 1'b0;
`endif
  assign used = (CW+1)'(count) + (CW+1)'(s0_v) + (CW+1)'(s1_v);
  assign ready = rdy_q & (used < FD);
  assign accept = bus.req_valid & ready;
  assign bus.req_ready = ready;
  // S0: drive the SRAM port; addr/wdata hold when idle or rejected so the SRAM sees a stable address
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdy_q <= 1'b0;
      s0_v <= 1'b0;
      s0_wr <= 1'b0;
      s0_err <= 1'b0;
      sram_wea <= '0;
      sram_addr <= '0;
      sram_wdata <= '0;
    end else begin
      rdy_q <= 1'b1;
      s0_v <= accept;
      s0_wr <= accept & (|req.be);
      s0_err <= accept & err;
      sram_wea <= (accept & !err) ? req.be : '0;
      if (accept & !err) begin
        sram_addr <= req.addr;
        sram_wdata <= req.wdata;
      end
    end
  // S1: tag follows the SRAM access while the registered read data forms
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_wr <= 1'b0;
      s1_err <= 1'b0;
    end else begin
      s1_v <= s0_v;
      s1_wr <= s0_wr;
      s1_err <= s0_err;
    end
  assign rsp_in = '{is_wr: s1_wr, err: s1_err, rdata: (s1_wr | s1_err) ? '0 : sram_rdata};
  sram_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s1_v),
    .pop   (rsp_v & bus.rsp_ready),
    .din   (rsp_in),
    .dout  (rsp_head),
    .count (count)
  );
  assign rsp_v = count != '0;
  assign bus.rsp_valid = rsp_v;
  assign bus.rsp_is_wr = rsp_v & rsp_head.is_wr;
  assign bus.rsp_err = rsp_v & rsp_head.err;
  assign bus.rsp_rdata = rsp_v ? rsp_head.rdata : '0;
endmodule

// File: tb/tb_sram_req_master.sv
// tb_sram_req_master: table-driven and scoreboard bench for sram_req_master with a 480x32 SRAM model
module tb_sram_req_master;
  import sram_req_pkg::*;
`ifdef SRAM_REQ_BOUNDS_CHK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] sram_wea;
  logic [15:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic [31:0] mem [480];
  int n_chk = 0, n_fail = 0, n_rsp = 0, cyc = 0;
  rsp_t exp_q[$];
  logic f_push = 1'b0, f_pop = 1'b0;
  rsp_t f_din, f_dout;
  logic [2:0] f_cnt;

  sram_req_if bus ();

  sram_req_master dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sram_wea   (sram_wea),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  sram_rsp_fifo #(.DEPTH(4)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (f_push),
    .pop   (f_pop),
    .din   (f_din),
    .dout  (f_dout),
    .count (f_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (sram_addr < 16'd480) begin
      for (int b = 0; b < 4; b++)
        if (sram_wea[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      sram_rdata <= mem[sram_addr];
    end else sram_rdata <= '0;
  end

  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    bus.req_valid && !bus.req_ready |=> bus.req_valid && $stable(bus.req_be) && $stable(bus.req_addr) && $stable(bus.req_wdata));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      n_rsp++;
      if (exp_q.size() == 0) check("rsp_unexpected", 64'(bus.rsp_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
      else check("rsp", 64'({bus.rsp_is_wr, bus.rsp_err, bus.rsp_rdata}), 64'(exp_q.pop_front()));
    end

  task automatic send(input logic [3:0] be, input logic [15:0] a, input logic [31:0] d,
                      input logic ew, input logic [31:0] er, input logic ee);
    int t = 0;
    bus.req_valid = 1'b1;
    bus.req_be = be;
    bus.req_addr = a;
    bus.req_wdata = d;
    @(negedge clk);
    while (!bus.req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (bus.req_ready) exp_q.push_back('{is_wr: ew, err: ee, rdata: er});
    else check("send_timeout", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  be;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        ew;
    logic [31:0] er;
  } vec_t;
  vec_t tbl [10];

  initial begin
    int k, acc, c4, c7, t, r0;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k, acc, c4, c7, t, r0;
    tbl[0] = '{4'b0101, 16'd7,   32'hAABBCCDD, 1'b1, 32'h0};
    tbl[1] = '{4'b0000, 16'd7,   32'h0,        1'b0, 32'h00BB00DD};
    tbl[2] = '{4'b0000, 16'd0,   32'h0,        1'b0, 32'h0};
    tbl[3] = '{4'b0000, 16'd479, 32'h0,        1'b0, 32'h1DF};
    tbl[4] = '{4'b1111, 16'd478, 32'h12345678, 1'b1, 32'h0};
    tbl[5] = '{4'b0000, 16'd478, 32'h0,        1'b0, 32'h12345678};
    tbl[6] = '{4'b0110, 16'd478, 32'hA5A5A5A5, 1'b1, 32'h0};
    tbl[7] = '{4'b0000, 16'd478, 32'h0,        1'b0, 32'h12A5A578};
    tbl[8] = '{4'b1000, 16'd3,   32'hFF000000, 1'b1, 32'h0};
    tbl[9] = '{4'b0000, 16'd3,   32'h0,        1'b0, 32'hFF000003};
    for (int i = 0; i < 480; i++) mem[i] = 32'(i);
    bus.req_valid = 1'b0;
    bus.req_be = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    f_din = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_sram", 64'({sram_wea, sram_addr, sram_wdata}), 64'd0);
    check("rst_rsp", 64'({bus.rsp_valid, bus.rsp_is_wr, bus.rsp_err, bus.rsp_rdata}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_edge", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    check("ready_after_edge", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    // single read: response exactly two edges after the accept edge
    bus.rsp_ready = 1'b1;
    send(4'b0000, 16'd5, 32'h0, 1'b0, 32'h5, 1'b0);
    @(negedge clk);
    check("rd5_addr", 64'({sram_wea, sram_addr}), 64'({4'b0000, 16'd5}));
    check("rd5_lat_n1", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    check("rd5_lat_n2", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    check("rd5_lat_n3", 64'(bus.rsp_valid), 64'd1);
    drain();
    // table of writes/reads, issued back to back
    for (int i = 0; i < 10; i++) send(tbl[i].be, tbl[i].addr, tbl[i].wdata, tbl[i].ew, tbl[i].er, 1'b0);
    drain();
    // credit stall: 8 reads with consumer blocked
    bus.rsp_ready = 1'b0;
    k = 0;
    acc = 0;
    bus.req_valid = 1'b1;
    bus.req_be = '0;
    bus.req_addr = 16'd10;
    repeat (12) begin
      @(negedge clk);
      if (bus.req_ready) begin
        exp_q.push_back('{is_wr: 1'b0, err: 1'b0, rdata: 32'(10 + k)});
        k++;
        acc++;
      end
      @(posedge clk);
      #1 bus.req_addr = 16'(10 + k);
    end
    check("burst_accepts", 64'(acc), 64'd4);
    check("burst_stalled", 64'(bus.req_ready), 64'd0);
    r0 = n_rsp;
    bus.rsp_ready = 1'b1;
    t = 0;
    c4 = 0;
    c7 = 0;
    while (k < 8 && t < 50) begin
      @(negedge clk);
      if (bus.req_ready) begin
        exp_q.push_back('{is_wr: 1'b0, err: 1'b0, rdata: 32'(10 + k)});
        if (k == 4) c4 = cyc;
        if (k == 7) c7 = cyc;
        k++;
      end
      @(posedge clk);
      #1 bus.req_addr = 16'(10 + k);
      t++;
    end
    bus.req_valid = 1'b0;
    check("burst_total", 64'(k), 64'd8);
    check("burst_rate", 64'(c7 - c4), 64'd3);
    drain();
    check("burst_rsp_count", 64'(n_rsp - r0), 64'd8);
    // standalone FIFO: steady push+pop at count 3
    f_push = 1'b1;
    for (int j = 0; j < 3; j++) begin
      f_din = '{is_wr: 1'b0, err: 1'b0, rdata: 32'(j)};
      @(posedge clk);
      #1;
    end
    f_push = 1'b0;
    @(negedge clk);
    check("fifo_fill", 64'(f_cnt), 64'd3);
    @(posedge clk);
    #1 f_push = 1'b1;
    f_pop = 1'b1;
    for (int j = 0; j < 20; j++) begin
      f_din = '{is_wr: 1'b0, err: 1'b0, rdata: 32'(3 + j)};
      @(negedge clk);
      check("fifo_pp_count", 64'(f_cnt), 64'd3);
      check("fifo_pp_head", 64'(f_dout.rdata), 64'(j));
      @(posedge clk);
      #1;
    end
    f_push = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("fifo_empty", 64'(f_cnt), 64'd0);
    @(negedge clk);
    check("fifo_pop_empty", 64'(f_cnt), 64'd0);
    @(posedge clk);
    #1 f_pop = 1'b0;
    // reset one cycle after a write accept aborts the write
    send(4'b1111, 16'd20, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
    check("rst_wea_pre", 64'(sram_wea), 64'hF);
    rst_n = 1'b0;
    #1;
    check("rst_wea_async", 64'(sram_wea), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_word", 64'(mem[20]), 64'h14);
    @(posedge clk);
    #1;
    send(4'b0000, 16'd20, 32'h0, 1'b0, 32'h14, 1'b0);
    drain();
    // out-of-range write, then read of the last word
    send(4'b1111, 16'd480, 32'h11111111, 1'b1, 32'h0, BCHK);
    check("oob_wea", 64'(sram_wea), BCHK ? 64'd0 : 64'hF);
    check("oob_addr", 64'(sram_addr), BCHK ? 64'd20 : 64'd480);
    send(4'b0000, 16'd479, 32'h0, 1'b0, 32'h1DF, 1'b0);
    drain();
    check("oob_word", 64'(mem[479]), 64'h1DF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
